rst_seq_ctrl: RTL and testbench
===============================

// Module: rst_seq_ctrl
// PURPOSE
//  Single-clock reset sequencer. Drives NUM_STG downstream active-low sync resets
//  (one per clk/rst_n pair handed to sub-blocks) and releases them in fixed order
//  0..NUM_STG-1. Each release is preceded by a per-stage delay and followed by a
//  ready handshake from that stage. Sits at chip/subsystem top; SW may re-run it.
// PARAMETERS
//  NUM_STG     4    number of sequenced reset outputs (1..16)
//  CNT_W       8    width of delay/timeout counters and per-stage delay fields
//  HOLD_CYC    16   cycles all outputs stay asserted before stage 0 handling (>=1)
//  ACK_TO      200  max cycles to wait for stg_ack[i] after release; 0 = no timeout
// PORTS
//  clk         in   1              clock
//  rst         in   1              synchronous, active-high reset
//  sw_rst_req  in   1              1-cycle pulse: restart full sequence
//  stg_dly     in   NUM_STG*CNT_W  delay before releasing stage i: bits [i*CNT_W +: CNT_W]
//  stg_ack     in   NUM_STG        stage i ready (level, sampled only in ACK_WAIT for i)
//  stg_rst_n   out  NUM_STG        active-low reset to stage i
//  seq_busy    out  1              sequence in progress
//  seq_done    out  1              all stages released and acked
//  seq_err     out  1              ack timeout occurred
//  err_stg     out  4              index of stage that timed out
// BEHAVIOUR
//  - Reset is synchronous, active-high, single clock domain. All outputs are registered.
//  - rst=1: state=HOLD, stg_rst_n=0, seq_busy=1, seq_done=0, seq_err=0,
//    err_stg=0, counters=0, stage idx=0.
//  - FSM states: HOLD -> DLY -> ACK_WAIT -> (DLY of next stage | DONE) ; ACK_WAIT -> ERR.
//  - HOLD: count HOLD_CYC cycles after rst deassertion, then go to DLY with idx=0.
//  - DLY: load cnt from stg_dly[idx] on entry.
//    - Stay cnt cycles (0 = zero extra cycles).
//    - On exit, stg_rst_n[idx]<=1 and enter ACK_WAIT.
//    - Release latency = HOLD_CYC + stg_dly[0] + 1 clocks from rst low to stg_rst_n[0] high.
//  - ACK_WAIT: stg_ack[idx]=1 sampled.
//    - If idx==NUM_STG-1 -> DONE, else idx+1 -> DLY.
//    - Ack is accepted in the same cycle stg_rst_n[idx] is seen high or later.
//  - ACK_WAIT timeout: if ACK_TO!=0 and ACK_TO cycles elapse without ack -> ERR.
//    - seq_err<=1, err_stg<=idx.
//    - Released stages stay released; unreleased stages stay in reset.
//  - DONE: seq_done=1, seq_busy=0. Outputs hold until rst or sw_rst_req.
//  - ERR: seq_busy=0, seq_done=0. Outputs hold until rst or sw_rst_req.
//  - stg_ack of stages other than idx is ignored. Ack dropping after acceptance is ignored.
//  - sw_rst_req=1, any state incl. mid-sequence: next cycle behaves exactly as rst
//    (all stg_rst_n=0, state HOLD, seq_err/seq_done cleared).
//    sw_rst_req has priority over a same-cycle ack or timeout.
//  - stg_dly is sampled only on DLY entry; later changes affect subsequent stages only.
//  - Counters saturate, never wrap. Timeout compare is cnt==ACK_TO-1 (exact ACK_TO cycles).
//  - Invariant: stg_rst_n is thermometer-coded (stage i released => all j<i released).
// TESTING
//  1 NUM_STG=4, HOLD_CYC=16, all stg_dly=0, acks tied 1
//    -> stg_rst_n 0000->0001->0011->0111->1111 on consecutive cycles from cycle 17;
//    -> seq_done=1 one cycle after last release.
//  2 stg_dly={5,0,10,3} (stage3..0), ack tied 1
//    -> release cycles 20, 31, 32, 38 after rst low; thermometer invariant holds.
//  3 ACK_TO=200, stg_ack[2] held 0
//    -> seq_err=1, err_stg=2 exactly 200 cycles after stg_rst_n[2] rose;
//    -> stg_rst_n=0111 held; seq_busy=0.
//  4 sw_rst_req pulse while in ACK_WAIT for stage 1 with stg_ack[1] rising same cycle
//    -> next cycle stg_rst_n=0000, state HOLD, full sequence reruns.
//  5 From ERR state, sw_rst_req -> seq_err cleared next cycle; sequence completes when acks return.
//  6 ACK_TO=0, ack withheld 10000 cycles -> no error; ack at 10001 -> sequence proceeds.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl
//    Single-clock reset sequencer. Holds NUM_STG downstream active-low resets
//    asserted for HOLD_CYC cycles, then releases them in order 0..NUM_STG-1.
//    Each release waits a per-stage delay and is followed by a ready handshake
//    from that stage. Software may restart the whole sequence at any time.
//
// Ports
//    clk         clock
//    rst         synchronous active-high reset
//    sw_rst_req  1-cycle pulse, restarts the full sequence (same effect as rst)
//    stg_dly     per-stage release delay, stage i at [i*CNT_W +: CNT_W]
//    stg_ack     per-stage ready level, only looked at while waiting on that stage
//    stg_rst_n   active-low reset per stage, thermometer coded
//    seq_busy    sequence in progress
//    seq_done    all stages released and acknowledged
//    seq_err     a stage failed to acknowledge within ACK_TO cycles
//    err_stg     index of the stage that timed out
module rst_seq_ctrl #(
   parameter int unsigned NUM_STG  = 4,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned HOLD_CYC = 16,
   parameter int unsigned ACK_TO   = 200
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sw_rst_req,
   input  logic [NUM_STG*CNT_W-1:0] stg_dly,
   input  logic [NUM_STG-1:0]       stg_ack,
   output logic [NUM_STG-1:0]       stg_rst_n,
   output logic                     seq_busy,
   output logic                     seq_done,
   output logic                     seq_err,
   output logic [3:0]               err_stg
);

   typedef enum logic [2:0] {
      S_HOLD,
      S_DLY,
      S_ACK_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ACK_TO - 1);
   localparam logic [3:0]       LAST_STG  = 4'(NUM_STG - 1);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [3:0]         idx, idx_nx;
   logic [NUM_STG-1:0] rstn_nx;
   logic               busy_nx, done_nx, err_nx;
   logic [3:0]         err_stg_nx;
   logic               enter;
   logic [3:0]         dly_idx;
   logic [CNT_W-1:0]   dly_sel;
   logic               ack_sel;

   // Stages 0..k released, the rest held in reset.
   function automatic logic [NUM_STG-1:0] therm(input logic [3:0] k);
      logic [NUM_STG-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < NUM_STG; i++)
         if (4'(i) <= k) v[i] = 1'b1;
      return v;
   endfunction

   // Stage whose delay gets loaded when a stage is entered: 0 out of HOLD,
   // otherwise the stage after the one just acknowledged.
   assign dly_idx = (state == S_HOLD) ? 4'd0 : idx + 4'd1;

   always_comb begin
      dly_sel = '0;
      ack_sel = 1'b0;
      for (int unsigned i = 0; i < NUM_STG; i++) begin
         if (4'(i) == dly_idx) dly_sel = stg_dly[i*CNT_W +: CNT_W];
         if (4'(i) == idx)     ack_sel = stg_ack[i];
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      idx_nx     = idx;
      rstn_nx    = stg_rst_n;
      err_stg_nx = err_stg;
      enter      = 1'b0;

      if (sw_rst_req) begin
         state_nx   = S_HOLD;
         cnt_nx     = '0;
         idx_nx     = '0;
         rstn_nx    = '0;
         err_stg_nx = '0;
      end else begin
         unique case (state)
            S_HOLD: begin
               if (cnt == HOLD_LAST)     enter  = 1'b1;
               else if (cnt != '1)       cnt_nx = cnt + 1'b1;
            end
            S_DLY: begin
               // Loaded with a non-zero delay; release on the last counted cycle.
               if (cnt <= CNT_W'(1)) begin
                  state_nx = S_ACK_WAIT;
                  cnt_nx   = '0;
                  rstn_nx  = therm(idx);
               end else begin
                  cnt_nx = cnt - 1'b1;
               end
            end
            S_ACK_WAIT: begin
               if (ack_sel) begin
                  if (idx == LAST_STG) state_nx = S_DONE;
                  else                 enter    = 1'b1;
               end else if ((ACK_TO != 0) && (cnt == TO_LAST)) begin
                  state_nx   = S_ERR;
                  err_stg_nx = idx;
               end else if (cnt != '1) begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            S_DONE, S_ERR: ;
            default: state_nx = S_HOLD;
         endcase

         // A zero delay releases the stage on the entry cycle itself, so
         // back-to-back stages with zero delay release on consecutive cycles.
         if (enter) begin
            idx_nx = dly_idx;
            if (dly_sel == '0) begin
               state_nx = S_ACK_WAIT;
               cnt_nx   = '0;
               rstn_nx  = therm(dly_idx);
            end else begin
               state_nx = S_DLY;
               cnt_nx   = dly_sel;
            end
         end
      end

      busy_nx = (state_nx == S_HOLD) || (state_nx == S_DLY) || (state_nx == S_ACK_WAIT);
      done_nx = (state_nx == S_DONE);
      err_nx  = (state_nx == S_ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_HOLD;
         cnt       <= '0;
         idx       <= '0;
         stg_rst_n <= '0;
         seq_busy  <= 1'b1;
         seq_done  <= 1'b0;
         seq_err   <= 1'b0;
         err_stg   <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         idx       <= idx_nx;
         stg_rst_n <= rstn_nx;
         seq_busy  <= busy_nx;
         seq_done  <= done_nx;
         seq_err   <= err_nx;
         err_stg   <= err_stg_nx;
      end
   end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
module tb_rst_seq_ctrl;

   localparam int NS  = 4;
   localparam int CW  = 8;
   localparam int HC  = 16;
   localparam int ATO = 200;
   localparam int INF = 1 << 30;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, sw_rst_req;
   logic [NS*CW-1:0]  stg_dly;
   logic [NS-1:0]     stg_ack, stg_rst_n;
   logic              seq_busy, seq_done, seq_err;
   logic [3:0]        err_stg;

   logic              rst0, sw0;
   logic [NS*CW-1:0]  dly0;
   logic [NS-1:0]     ack0, rstn0;
   logic              busy0, done0, err0;
   logic [3:0]        estg0;

   rst_seq_ctrl #(.NUM_STG(NS), .CNT_W(CW), .HOLD_CYC(HC), .ACK_TO(ATO)) dut (
      .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .stg_dly(stg_dly),
      .stg_ack(stg_ack), .stg_rst_n(stg_rst_n), .seq_busy(seq_busy),
      .seq_done(seq_done), .seq_err(seq_err), .err_stg(err_stg));

   rst_seq_ctrl #(.NUM_STG(NS), .CNT_W(CW), .HOLD_CYC(HC), .ACK_TO(0)) dut_noto (
      .clk(clk), .rst(rst0), .sw_rst_req(sw0), .stg_dly(dly0),
      .stg_ack(ack0), .stg_rst_n(rstn0), .seq_busy(busy0),
      .seq_done(done0), .seq_err(err0), .err_stg(estg0));

   int n_cmp = 0;
   int n_bad = 0;

   // Timeline of the current sequence in edges after the start pulse.
   int d[NS], r[NS], a[NS], acc[NS], ld[NS];
   int spec2[NS] = '{3, 10, 0, 5};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // dmode: 0 random delays/acks, 1 zero delays acks tied high, 2 fixed delays acks tied high
   // to_stage: stage that never acks (-1 none)
   // abort_mode: 0 none, 1 sw restart at random edge, 2 sw restart as stage 1 ack rises
   task automatic run_trial(input bit use_sw, input int dmode, input int to_stage, input int abort_mode);
      int t, end_t, abort_at, n;
      bit to_hit;
      rst        = !use_sw;
      sw_rst_req = use_sw;
      stg_ack    = '1;
      stg_dly    = $urandom;
      @(posedge clk); #1;
      rst        = 1'b0;
      sw_rst_req = 1'b0;
      check_eq("start_rstn", 32'(stg_rst_n), 32'd0);
      check_eq("start_busy", 32'(seq_busy), 32'd1);
      check_eq("start_done", 32'(seq_done), 32'd0);
      check_eq("start_err", 32'(seq_err), 32'd0);
      check_eq("start_estg", 32'(err_stg), 32'd0);

      for (int i = 0; i < NS; i++) begin
         if (dmode == 1)      d[i] = 0;
         else if (dmode == 2) d[i] = spec2[i];
         else if ($urandom_range(0, 7) == 0) d[i] = int'($urandom_range(100, 255));
         else                 d[i] = int'($urandom_range(0, 12));
         r[i] = INF; a[i] = INF; acc[i] = INF; ld[i] = INF;
      end
      t = HC + 1;
      to_hit = 1'b0;
      for (int i = 0; i < NS; i++) begin
         if (!to_hit) begin
            ld[i] = t;
            r[i]  = t + d[i];
            if (i == to_stage) begin
               to_hit = 1'b1;
            end else begin
               a[i] = (dmode != 0) ? 0 : r[i] + int'($urandom_range(0, 6)) - 2;
               if (abort_mode == 2 && i == 1) a[i] = r[i] + 3;
               acc[i] = (a[i] > r[i] + 1) ? a[i] : r[i] + 1;
               t = acc[i];
            end
         end
      end
      end_t = to_hit ? r[to_stage] + ATO : acc[NS-1];
      abort_at = 0;
      if (abort_mode == 1)
         abort_at = int'($urandom_range(1, end_t - 1));
      else if (abort_mode == 2 && !(to_hit && to_stage <= 1))
         abort_at = acc[1];

      for (int e = 1; e <= end_t + 8; e++) begin
         if (e == abort_at) return;
         for (int i = 0; i < NS; i++) begin
            stg_dly[i*CW +: CW] = (e <= ld[i]) ? CW'(d[i]) : CW'($urandom);
            if (e > r[i] && e <= acc[i]) stg_ack[i] = (e >= a[i]);
            else                         stg_ack[i] = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         n = 0;
         for (int i = 0; i < NS; i++) if (r[i] <= e) n++;
         check_eq($sformatf("rstn@%0d", e), 32'(stg_rst_n), 32'((1 << n) - 1));
         check_eq($sformatf("busy@%0d", e), 32'(seq_busy), 32'(e < end_t));
         check_eq($sformatf("done@%0d", e), 32'(seq_done), 32'(!to_hit && e >= end_t));
         check_eq($sformatf("err@%0d", e), 32'(seq_err), 32'(to_hit && e >= end_t));
         check_eq($sformatf("estg@%0d", e), 32'(err_stg),
                  (to_hit && e >= end_t) ? 32'(to_stage) : 32'd0);
      end
   endtask

   // No-timeout instance: ack withheld for 10000 cycles, then granted.
   task automatic run_noto();
      logic bad;
      int   exp_rn[4] = '{3, 7, 15, 15};
      rst0 = 1'b1; dly0 = '0; ack0 = '0;
      @(posedge clk); #1;
      rst0 = 1'b0;
      for (int e = 1; e <= HC + 1; e++) begin
         @(posedge clk); #1;
      end
      check_eq("noto_rel0", 32'(rstn0), 32'd1);
      bad = 1'b0;
      for (int k = 0; k < 10000; k++) begin
         @(posedge clk); #1;
         if (err0 || !busy0 || rstn0 != 4'b0001 || done0) bad = 1'b1;
      end
      check_eq("noto_wait", 32'(bad), 32'd0);
      ack0 = '1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check_eq($sformatf("noto_rn%0d", k), 32'(rstn0), 32'(exp_rn[k]));
      end
      check_eq("noto_done", 32'(done0), 32'd1);
      check_eq("noto_err", 32'(err0), 32'd0);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sw_rst_req = 1'b0; stg_dly = '0; stg_ack = '0;
      rst0 = 1'b1; sw0 = 1'b0; dly0 = '0; ack0 = '0;
      run_trial(1'b0, 1, -1, 0);
      run_trial(1'b1, 2, -1, 0);
      run_trial(1'b1, 0,  2, 0);
      run_trial(1'b1, 0, -1, 2);
      run_trial(1'b1, 0, -1, 0);
      for (int k = 0; k < 20; k++)
         run_trial(1'($urandom_range(0, 1)), 0,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS - 1)) : -1,
                   int'($urandom_range(0, 2)));
      run_trial(1'b1, 0, -1, 0);
      run_noto();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
